// File: rtl/max_pool.sv
// -----------------------------------------------------------------------------
// max_pool
//   2x2, stride-2 max pooling over NUM_CHNL feature maps held in DRAM.
//   Each output word costs four DRAM reads (one per window element) followed
//   by one DRAM write of the window maximum. Outputs are written sequentially
//   from OUT_BASE, walking channel-major, then row, then column.
//
//   Optional feature macro: POOL_RELU_EN
//     defined   : negative maxima are written as 0 (ReLU after pooling)
//     undefined : the raw signed maximum is written
//
// Ports
//   clk         single clock, rising edge
//   srst        synchronous active-high reset
//   enable      start/run request; dropping it aborts a run or leaves DONE
//   dram_valid  read data on data_in valid this cycle
//   data_in     DRAM read data (signed activation)
//   data_out    pooled write data (0 when dram_en_wr=0)
//   addr_in     DRAM read address (0 when dram_en_rd=0)
//   addr_out    DRAM write address (0 when dram_en_wr=0)
//   dram_en_rd  read request, held until dram_valid
//   dram_en_wr  one-cycle write strobe
//   done        all channels pooled (held while enable=1)
// -----------------------------------------------------------------------------
module max_pool #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 18,
    parameter int FMAP_WIDTH  = 24,
    parameter int FMAP_HEIGHT = 24,
    parameter int NUM_CHNL    = 6,
    parameter logic [ADDR_WIDTH-1:0] IN_BASE  = 18'd0,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE = 18'd4096
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] FRAME_SZ = ADDR_WIDTH'(FMAP_WIDTH * FMAP_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_SZ   = ADDR_WIDTH'(FMAP_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] X_LAST   = ADDR_WIDTH'(FMAP_WIDTH / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] R_LAST   = ADDR_WIDTH'(FMAP_HEIGHT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] C_LAST   = ADDR_WIDTH'(NUM_CHNL - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   c_q, c_d, r_q, r_d, x_q, x_d, idx_q, idx_d;
    logic [1:0]              k_q, k_d;          // window element: {dy,dx}
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic                    rd_q, rd_d, wr_q, wr_d, done_q, done_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [ADDR_WIDTH-1:0]   ain_q, ain_d, aout_q, aout_d;

    logic [DATA_WIDTH-1:0]   win_max_s;
    logic [ADDR_WIDTH-1:0]   c_nx_s, r_nx_s, x_nx_s;
    logic                    last_win_s;

    // Read address of window element k for output position (c, r, x).
    function automatic logic [ADDR_WIDTH-1:0] rd_addr(
        input logic [ADDR_WIDTH-1:0] c,
        input logic [ADDR_WIDTH-1:0] r,
        input logic [ADDR_WIDTH-1:0] x,
        input logic [1:0]            k
    );
        logic [ADDR_WIDTH-1:0] row;
        logic [ADDR_WIDTH-1:0] col;
        row = {r[ADDR_WIDTH-2:0], k[1]};
        col = {x[ADDR_WIDTH-2:0], k[0]};
        return IN_BASE + c * FRAME_SZ + row * ROW_SZ + col;
    endfunction

    // Value written for a finished window.
    function automatic logic [DATA_WIDTH-1:0] out_val(input logic [DATA_WIDTH-1:0] v);
`ifdef POOL_RELU_EN
        return v[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    // Running maximum including the word arriving this cycle; first word loads directly.
    always_comb begin
        win_max_s = max_q;
        if (k_q == 2'd0) begin
            win_max_s = data_in;
        end else if ($signed(data_in) > $signed(max_q)) begin
            win_max_s = data_in;
        end else begin
            win_max_s = max_q;
        end
    end

    // Next output position in channel/row/column order.
    always_comb begin
        last_win_s = (x_q == X_LAST) && (r_q == R_LAST) && (c_q == C_LAST);
        c_nx_s     = c_q;
        r_nx_s     = r_q;
        x_nx_s     = x_q + ONE_A;
        if (x_q == X_LAST) begin
            x_nx_s = '0;
            if (r_q == R_LAST) begin
                r_nx_s = '0;
                c_nx_s = c_q + ONE_A;
            end else begin
                r_nx_s = r_q + ONE_A;
            end
        end else begin
            x_nx_s = x_q + ONE_A;
        end
    end

    // Next-state and next-output logic; strobes and buses default to 0 each cycle.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        x_d     = x_q;
        k_d     = k_q;
        idx_d   = idx_q;
        max_d   = max_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        dout_d  = '0;
        ain_d   = '0;
        aout_d  = '0;
        case (state_q)
            S_IDLE: begin
                c_d   = '0;
                r_d   = '0;
                x_d   = '0;
                k_d   = 2'd0;
                idx_d = '0;
                max_d = '0;
                if (enable) begin
                    state_d = S_READ;
                    rd_d    = 1'b1;
                    ain_d   = rd_addr('0, '0, '0, 2'd0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    c_d     = '0;
                    r_d     = '0;
                    x_d     = '0;
                    k_d     = 2'd0;
                    idx_d   = '0;
                    max_d   = '0;
                end else if (dram_valid) begin
                    max_d = win_max_s;
                    if (k_q == 2'd3) begin
                        state_d = S_WRITE;
                        k_d     = 2'd0;
                        wr_d    = 1'b1;
                        dout_d  = out_val(win_max_s);
                        aout_d  = OUT_BASE + idx_q;
                    end else begin
                        k_d   = k_q + 2'd1;
                        rd_d  = 1'b1;
                        ain_d = rd_addr(c_q, r_q, x_q, k_q + 2'd1);
                    end
                end else begin
                    // Hold the request until the DRAM answers.
                    rd_d  = 1'b1;
                    ain_d = ain_q;
                end
            end
            S_WRITE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    c_d     = '0;
                    r_d     = '0;
                    x_d     = '0;
                    k_d     = 2'd0;
                    idx_d   = '0;
                    max_d   = '0;
                end else if (last_win_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ;
                    idx_d   = idx_q + ONE_A;
                    c_d     = c_nx_s;
                    r_d     = r_nx_s;
                    x_d     = x_nx_s;
                    rd_d    = 1'b1;
                    ain_d   = rd_addr(c_nx_s, r_nx_s, x_nx_s, 2'd0);
                end
            end
            S_DONE: begin
                if (enable) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            r_q     <= '0;
            x_q     <= '0;
            k_q     <= 2'd0;
            idx_q   <= '0;
            max_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            ain_q   <= '0;
            aout_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            x_q     <= x_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            ain_q   <= ain_d;
            aout_q  <= aout_d;
        end
    end

    assign data_out   = dout_q;
    assign addr_in    = ain_q;
    assign addr_out   = aout_q;
    assign dram_en_rd = rd_q;
    assign dram_en_wr = wr_q;
    assign done       = done_q;

endmodule

// File: tb/tb_max_pool.sv
// -----------------------------------------------------------------------------
// tb_max_pool
//   Directed bench for max_pool configured as 4x4 maps, 2 channels,
//   IN_BASE=0, OUT_BASE=4096. A small DRAM responder returns mem[addr_in]
//   and can withhold dram_valid for a chosen address.
// -----------------------------------------------------------------------------
module tb_max_pool;

    localparam int DW = 32;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          srst;
    logic          enable;
    logic          dram_valid;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] addr_out;
    logic          dram_en_rd;
    logic          dram_en_wr;
    logic          done;

    always #5 clk = ~clk;

    max_pool #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FMAP_WIDTH (4),
        .FMAP_HEIGHT(4),
        .NUM_CHNL   (2),
        .IN_BASE    (18'd0),
        .OUT_BASE   (18'd4096)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .enable    (enable),
        .dram_valid(dram_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .addr_in   (addr_in),
        .addr_out  (addr_out),
        .dram_en_rd(dram_en_rd),
        .dram_en_wr(dram_en_wr),
        .done      (done)
    );

    logic [DW-1:0] mem [0:31];
    int            checks = 0;
    int            errors = 0;
    int            stall_addr = -1;
    int            stall_left = 0;
    int            overlap = 0;
    logic          wr_prev = 1'b0;
    logic [AW-1:0] cap_q [$];
    logic [AW-1:0] wa_q  [$];
    logic [DW-1:0] wd_q  [$];

    // Full-run expectations: channel 0 maxima are bottom-right words,
    // channel 1 (negated contents) maxima are top-left words.
`ifdef POOL_RELU_EN
    logic [DW-1:0] exp_c [0:7] = '{32'd5, 32'd7, 32'd13, 32'd15,
                                   32'd0, 32'd0, 32'd0, 32'd0};
    logic [DW-1:0] exp_b = 32'd0;
`else
    logic [DW-1:0] exp_c [0:7] = '{32'd5, 32'd7, 32'd13, 32'd15,
                                   32'hFFFF_FFF0, 32'hFFFF_FFEE, 32'hFFFF_FFE8, 32'hFFFF_FFE6};
    logic [DW-1:0] exp_b = 32'hFFFF_FFFE;
`endif
    logic [AW-1:0] exp_last_rd [0:3] = '{18'd26, 18'd27, 18'd30, 18'd31};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Log the cycle that is ending, advance one clock, then answer the new read.
    task automatic tick();
        if (dram_en_rd === 1'b1 && dram_valid === 1'b1) cap_q.push_back(addr_in);
        if (dram_en_wr === 1'b1) begin
            wa_q.push_back(addr_out);
            wd_q.push_back(data_out);
        end
        if (dram_en_rd === 1'b1 && dram_en_wr === 1'b1) overlap++;
        wr_prev = dram_en_wr;
        @(posedge clk);
        #1;
        data_in = mem[addr_in[4:0]];
        if (dram_en_rd === 1'b1 && int'(addr_in) == stall_addr && stall_left > 0) begin
            dram_valid = 1'b0;
            stall_left--;
        end else begin
            dram_valid = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   64'(dram_en_rd), 64'd0);
        check({tag, "_wr"},   64'(dram_en_wr), 64'd0);
        check({tag, "_done"}, 64'(done),       64'd0);
        check({tag, "_dout"}, 64'(data_out),   64'd0);
        check({tag, "_ain"},  64'(addr_in),    64'd0);
        check({tag, "_aout"}, 64'(addr_out),   64'd0);
    endtask

    initial begin
        int n;
        int hold1;
        int w0;
        int c0;

        srst       = 1'b1;
        enable     = 1'b0;
        dram_valid = 1'b0;
        data_in    = '0;
        for (int a = 0; a < 32; a++) mem[a] = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        srst = 1'b0;
        tick();

        // Window {3,-7,12,5}, dram_valid tied high
        mem[0] = 32'd3;
        mem[1] = 32'hFFFF_FFF9;
        mem[4] = 32'd12;
        mem[5] = 32'd5;
        enable = 1'b1;
        tick();
        check("A_first_rd", 64'(dram_en_rd), 64'd1);
        check("A_first_addr", 64'(addr_in), 64'd0);
        n = 1;                       // cycles counted from the first read cycle
        while (dram_en_wr !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("A_write_cycle", 64'(n), 64'd5);
        check("A_data", 64'(data_out), 64'd12);
        check("A_waddr", 64'(addr_out), 64'd4096);
        check("A_ain_in_write", 64'(addr_in), 64'd0);
        tick();
        check("A_aout_idle", 64'(addr_out), 64'd0);
        check("A_dout_idle", 64'(data_out), 64'd0);
        check("A_next_window", 64'(addr_in), 64'd2);
        // Drop enable mid-read: abort, nothing further written
        enable = 1'b0;
        tick();
        check("A_abort_rd", 64'(dram_en_rd), 64'd0);
        repeat (12) tick();
        check("A_no_more_writes", 64'(wa_q.size()), 64'd1);

        // Window {-9,-2,-5,-4} with the second read stalled 3 cycles
        mem[0] = 32'hFFFF_FFF7;
        mem[1] = 32'hFFFF_FFFE;
        mem[4] = 32'hFFFF_FFFB;
        mem[5] = 32'hFFFF_FFFC;
        stall_addr = 1;
        stall_left = 3;
        enable = 1'b1;
        tick();
        check("B_restart_rd", 64'(dram_en_rd), 64'd1);
        check("B_restart_addr", 64'(addr_in), 64'd0);
        n = 1;
        hold1 = 0;
        while (dram_en_wr !== 1'b1 && n < 30) begin
            tick();
            n++;
            if (dram_en_rd === 1'b1 && addr_in == 18'd1) hold1++;
        end
        check("B_addr1_hold", 64'(hold1), 64'd4);
        check("B_write_cycle", 64'(n), 64'd8);
        check("B_data", 64'(data_out), 64'(exp_b));
        check("B_waddr", 64'(addr_out), 64'd4096);
        enable = 1'b0;
        tick();
        tick();

        // Full run over both channels
        for (int a = 0; a < 32; a++) mem[a] = (a < 16) ? 32'(a) : 32'(-a);
        w0 = wa_q.size();
        c0 = cap_q.size();
        enable = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("C_done", 64'(done), 64'd1);
        check("C_done_after_last_write", 64'(wr_prev), 64'd1);
        check("C_write_count", 64'(wa_q.size() - w0), 64'd8);
        check("C_read_count", 64'(cap_q.size() - c0), 64'd32);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("C_waddr%0d", i), 64'(wa_q[w0 + i]), 64'(4096 + i));
            check($sformatf("C_wdata%0d", i), 64'(wd_q[w0 + i]), 64'(exp_c[i]));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("C_last_rd%0d", i), 64'(cap_q[c0 + 28 + i]), 64'(exp_last_rd[i]));
        end
        repeat (3) tick();
        check("C_done_held", 64'(done), 64'd1);
        enable = 1'b0;
        tick();
        check("C_done_clear", 64'(done), 64'd0);
        tick();

        // srst after the second read of window index 3 (addresses 10,11,14,15)
        w0 = wa_q.size();
        c0 = cap_q.size();
        enable = 1'b1;
        n = 0;
        while (cap_q.size() < c0 + 14 && n < 200) begin
            tick();
            n++;
        end
        check("D_third_read_addr", 64'(addr_in), 64'd14);
        srst = 1'b1;
        tick();
        check_all_zero("D_srst");
        srst = 1'b0;
        tick();
        check("D_writes_before", 64'(wa_q.size() - w0), 64'd3);
        check("D_restart_rd", 64'(dram_en_rd), 64'd1);
        check("D_restart_addr", 64'(addr_in), 64'd0);
        n = 1;
        while (dram_en_wr !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("D_waddr", 64'(addr_out), 64'd4096);
        check("D_data", 64'(data_out), 64'd5);
        enable = 1'b0;
        tick();

        check("rd_wr_exclusive", 64'(overlap), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
